// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: FSM states, parity-type encoding,
// latched frame configuration and the 2-of-3 vote helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } rx_cfg_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter; maj/maj_vld are
// registered, so the vote is visible the cycle after the third sample.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  start,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx,
  output logic                  maj,
  output logic                  maj_vld
);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] half;
  logic [1:0]            smp;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      smp     <= '0;
      maj     <= 1'b1;
      maj_vld <= 1'b0;
    end else begin
      maj_vld <= 1'b0;
      // The start-detect cycle is count 0, so the counter resumes at 1.
      if (run) cnt <= (cnt == prescale - ONE) ? '0 : cnt + ONE;
      else     cnt <= start ? ONE : '0;
      if (run) begin
        if (cnt == half - ONE) smp[0] <= rx;
        if (cnt == half)       smp[1] <= rx;
        if (cnt == half + ONE) begin
          maj     <= maj3(smp[0], smp[1], rx);
          maj_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with majority-vote sampling and ready/valid output.
// Define UART_RX_BREAK_DET_EN to add the break_det output.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                  break_det
`endif
);
  localparam int             BCW      = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BC_ONE   = BCW'(1);

  rx_state_e             state, state_n;
  logic [1:0]            sync_q;
  logic                  rx_s, rx_prev;
  logic [PRESCALE_W-1:0] presc_q;
  rx_cfg_t               cfg_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc, stop_bad;
  logic                  maj, maj_vld;
  logic                  start_det, frame_done;
  logic                  perr, serr, brk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      rx_prev <= sync_q[1];
    end
  end
  assign rx_s = sync_q[1];

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .start    (start_det),
    .prescale (presc_q),
    .rx       (rx_s),
    .maj      (maj),
    .maj_vld  (maj_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (rx_prev && !rx_s) begin
                state_n   = START;
                start_det = 1'b1;
              end
      START:  if (maj_vld) state_n = maj ? IDLE : DATA;
      DATA:   if (maj_vld && bit_cnt == LAST_BIT) state_n = cfg_q.par_en ? PARITY : STOP;
      PARITY: if (maj_vld) state_n = STOP;
      STOP:   if (maj_vld && (!cfg_q.stop2 || bit_cnt == BC_ONE)) begin
                state_n    = IDLE;
                frame_done = 1'b1;
              end
      default: state_n = IDLE;
    endcase
  end

  // par_acc already holds data ^ parity bit by the time the frame is judged.
  assign perr = cfg_q.par_en && (par_acc != (cfg_q.par_typ == PAR_ODD));
  assign serr = stop_bad | ~maj;

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      cfg_q        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      stop_bad     <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
      if (start_det) begin
        presc_q  <= prescale;
        cfg_q    <= '{par_en: par_en, par_typ: par_typ, stop2: stop2};
        bit_cnt  <= '0;
        par_acc  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (maj_vld) begin
        case (state)
          DATA: begin
            shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
            par_acc <= par_acc ^ maj;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BC_ONE;
          end
          PARITY: par_acc <= par_acc ^ maj;
          STOP: begin
            stop_bad <= stop_bad | ~maj;
            bit_cnt  <= bit_cnt + BC_ONE;
          end
          default: ;
        endcase
      end
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (frame_done) begin
        if (!perr && !serr) begin
          if (!data_valid || data_ready) begin
            p_data     <= shreg;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          parity_error <= perr;
          stop_error   <= serr & ~brk;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Line held low through every sample: report a break rather than a framing error.
  // Re-arming needs a fresh 1->0 edge, so the receiver naturally waits for idle high.
  logic zero_acc;
  always_ff @(posedge clk) begin
    if (!rst) begin
      zero_acc  <= 1'b1;
      break_det <= 1'b0;
    end else begin
      break_det <= frame_done & zero_acc & ~maj;
      if (start_det)    zero_acc <= 1'b1;
      else if (maj_vld) zero_acc <= zero_acc & ~maj;
    end
  end
  assign brk = zero_acc & ~maj;
`else
  assign brk = 1'b0;
`endif

endmodule
